// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline: ALU opcodes, result-source
// selects and forwarding-mux selects.
package pipeline_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   // 2'b11 is not a legal select; the operand muxes treat it as FWD_RF.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: eight operations, modulo 2^XLEN, plus a zero flag
// used by the branch decision.
module alu
   import pipeline_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      alu_control,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic [XLEN-1:0] alu_result,
   output logic            zero
);

   localparam int SHAMT_W = $clog2(XLEN);

   logic [SHAMT_W-1:0] shamt;
   assign shamt = src_b[SHAMT_W-1:0];

   // NOTE: every output of a combinational block gets a default on entry so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      alu_result = '0;
      unique case (alu_op_e'(alu_control))
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_XOR: alu_result = src_a ^ src_b;
         ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLL: alu_result = src_a << shamt;
         ALU_SRL: alu_result = src_a >> shamt;
         default: alu_result = '0;
      endcase
   end

   assign zero = (alu_result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I core: operand forwarding, ALU, branch/jump
// decision and the EX/MEM pipeline register.
module execute_stage
   import pipeline_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  FlushM,
   input  logic                  ValidE,
   input  logic                  RegWriteE,
   input  logic                  MemWriteE,
   input  logic [1:0]            ResultSrcE,
   input  logic                  BranchE,
   input  logic                  JumpE,
   input  logic                  ALUSrcE,
   input  logic [2:0]            ALUControlE,
   input  logic [XLEN-1:0]       RD1_E,
   input  logic [XLEN-1:0]       RD2_E,
   input  logic [XLEN-1:0]       Imm_Ext_E,
   input  logic [REG_ADDR_W-1:0] RD_E,
   input  logic [XLEN-1:0]       PCE,
   input  logic [XLEN-1:0]       PCPlus4E,
   input  logic [1:0]            ForwardAE,
   input  logic [1:0]            ForwardBE,
   input  logic [XLEN-1:0]       ResultW,
   output logic                  PCSrcE,
   output logic [XLEN-1:0]       PCTargetE,
   output logic                  ValidM,
   output logic                  RegWriteM,
   output logic                  MemWriteM,
   output logic [1:0]            ResultSrcM,
   output logic [REG_ADDR_W-1:0] RD_M,
   output logic [XLEN-1:0]       ALUResultM,
   output logic [XLEN-1:0]       WriteDataM,
   output logic [XLEN-1:0]       PCPlus4M
);

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_write;
      logic [1:0]            result_src;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       alu_result;
      logic [XLEN-1:0]       write_data;
      logic [XLEN-1:0]       pc_plus4;
   } ex_mem_t;

   ex_mem_t ex_mem_d, ex_mem_q;

   logic [XLEN-1:0] src_a, write_data_e, src_b, alu_result_e;
   logic            zero_e;

   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                               input logic [XLEN-1:0] rf_val,
                                               input logic [XLEN-1:0] wb_val,
                                               input logic [XLEN-1:0] mem_val);
      case (fwd_sel_e'(sel))
         FWD_WB:  return wb_val;
         FWD_MEM: return mem_val;
         default: return rf_val;
      endcase
   endfunction

   // The M-stage operand is the registered result, so forwarding never closes
   // a combinational loop through the ALU.
   assign src_a        = fwd_mux(ForwardAE, RD1_E, ResultW, ex_mem_q.alu_result);
   assign write_data_e = fwd_mux(ForwardBE, RD2_E, ResultW, ex_mem_q.alu_result);
   assign src_b        = ALUSrcE ? Imm_Ext_E : write_data_e;

   alu #(.XLEN(XLEN)) u_alu (
      .alu_control (ALUControlE),
      .src_a       (src_a),
      .src_b       (src_b),
      .alu_result  (alu_result_e),
      .zero        (zero_e)
   );

   assign PCSrcE    = rst & ValidE & ((BranchE & zero_e) | JumpE);
   assign PCTargetE = PCE + Imm_Ext_E;

   // A flush or a bubble loads an all-zero entry; flush takes priority.
   always_comb begin
      ex_mem_d = '0;
      if (ValidE && !FlushM) begin
         ex_mem_d.valid      = 1'b1;
         ex_mem_d.reg_write  = RegWriteE;
         ex_mem_d.mem_write  = MemWriteE;
         ex_mem_d.result_src = ResultSrcE;
         ex_mem_d.rd         = RD_E;
         ex_mem_d.alu_result = alu_result_e;
         ex_mem_d.write_data = write_data_e;
         ex_mem_d.pc_plus4   = PCPlus4E;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its input from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ex_mem_q <= '0;
      else      ex_mem_q <= ex_mem_d;
   end

   assign ValidM     = ex_mem_q.valid;
   assign RegWriteM  = ex_mem_q.reg_write;
   assign MemWriteM  = ex_mem_q.mem_write;
   assign ResultSrcM = ex_mem_q.result_src;
   assign RD_M       = ex_mem_q.rd;
   assign ALUResultM = ex_mem_q.alu_result;
   assign WriteDataM = ex_mem_q.write_data;
   assign PCPlus4M   = ex_mem_q.pc_plus4;

endmodule
